// File: rtl/beat_sequencer.sv
// beat_sequencer: steps through a note chart ROM, one word per beat_clk rise.
// Emits a one-cycle note strobe with a 4-bit arrow mask per chart word.
module beat_sequencer #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat_clk,
  input  logic              start,
  input  logic              pause,
  output logic [ADDR_W-1:0] chart_addr,
  input  logic [4:0]        chart_data,
  output logic              note_valid,
  output logic [3:0]        note_mask,
  output logic [ADDR_W-1:0] beat_index,
  output logic              playing,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic s1;
  logic s2;
  logic s3;
  logic beat_tick;
  logic last_addr;
  logic end_mark;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= beat_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign beat_tick = s2 & ~s3;
  assign last_addr = (beat_index == {ADDR_W{1'b1}});
  assign end_mark  = chart_data[4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (beat_tick && !pause) state_nxt = READ;
      end
      READ: begin
        if (end_mark || last_addr) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        if (start) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Index saturates at the last address; DONE is the only exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_valid <= 1'b0;
      note_mask  <= 4'd0;
      beat_index <= '0;
    end else begin
      note_valid <= 1'b0;
      if ((state == IDLE || state == DONE) && start) begin
        beat_index <= '0;
      end
      if (state == READ && !end_mark) begin
        note_valid <= 1'b1;
        note_mask  <= chart_data[3:0];
        if (!last_addr) begin
          beat_index <= beat_index + ADDR_W'(1);
        end
      end
    end
  end

  always_comb begin
    playing = (state == RUN) || (state == READ);
    done    = (state == DONE);
  end

  assign chart_addr = beat_index;

endmodule

// File: tb/tb_beat_sequencer.sv
// tb_beat_sequencer: directed checks of beat_sequencer with a behavioural
// synchronous chart ROM; one 10-bit instance and one 2-bit instance.
module tb_beat_sequencer;

  logic       clk;
  logic       rst;
  logic       pause;

  logic       bclk1;
  logic       start1;
  logic [9:0] addr1;
  logic [4:0] cd1;
  logic       nv1;
  logic [3:0] mask1;
  logic [9:0] idx1;
  logic       play1;
  logic       done1;

  logic       bclk2;
  logic       start2;
  logic [1:0] addr2;
  logic [4:0] cd2;
  logic       nv2;
  logic [3:0] mask2;
  logic [1:0] idx2;
  logic       play2;
  logic       done2;

  logic [4:0] rom1 [0:1023];
  logic [4:0] rom2 [0:3];

  int checks;
  int passes;
  int nv_cnt;

  beat_sequencer #(.ADDR_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .beat_clk   (bclk1),
    .start      (start1),
    .pause      (pause),
    .chart_addr (addr1),
    .chart_data (cd1),
    .note_valid (nv1),
    .note_mask  (mask1),
    .beat_index (idx1),
    .playing    (play1),
    .done       (done1)
  );

  beat_sequencer #(.ADDR_W(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .beat_clk   (bclk2),
    .start      (start2),
    .pause      (1'b0),
    .chart_addr (addr2),
    .chart_data (cd2),
    .note_valid (nv2),
    .note_mask  (mask2),
    .beat_index (idx2),
    .playing    (play2),
    .done       (done2)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) begin
    cd1 <= rom1[addr1];
    cd2 <= rom2[addr2];
  end

  always @(posedge clk) begin
    if (nv1 === 1'b1) nv_cnt <= nv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic get_nv(input bit u2);
    return u2 ? nv2 : nv1;
  endfunction

  function automatic logic [3:0] get_mask(input bit u2);
    return u2 ? mask2 : mask1;
  endfunction

  function automatic logic [31:0] get_idx(input bit u2);
    return u2 ? 32'(idx2) : 32'(idx1);
  endfunction

  // One beat_clk rise; strobe expected 4 posedges after the drive point.
  task automatic do_beat(input bit u2, input bit exp_v,
                         input logic [3:0] exp_m, input int exp_idx,
                         input string tag);
    @(negedge clk);
    if (u2) bclk2 = 1'b1;
    else bclk1 = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk({tag, "_early"}, 32'(get_nv(u2)), 0);
    @(posedge clk);
    #1 chk({tag, "_valid"}, 32'(get_nv(u2)), 32'(exp_v));
    if (exp_v) chk({tag, "_mask"}, 32'(get_mask(u2)), 32'(exp_m));
    @(posedge clk);
    #1 chk({tag, "_pulse"}, 32'(get_nv(u2)), 0);
    chk({tag, "_idx"}, get_idx(u2), 32'(exp_idx));
    repeat (4) @(negedge clk);
    if (u2) bclk2 = 1'b0;
    else bclk1 = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_start(input bit u2, input string tag);
    @(negedge clk);
    if (u2) start2 = 1'b1;
    else start1 = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_play"}, 32'(u2 ? play2 : play1), 1);
    chk({tag, "_done"}, 32'(u2 ? done2 : done1), 0);
    chk({tag, "_idx"}, get_idx(u2), 0);
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  initial begin
    int c0;
    checks = 0;
    passes = 0;
    nv_cnt = 0;
    rst    = 1'b1;
    pause  = 1'b0;
    bclk1  = 1'b0;
    bclk2  = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    for (int i = 0; i < 1024; i++) rom1[i] = 5'h00;
    rom1[0] = 5'h01;
    rom1[1] = 5'h06;
    rom1[2] = 5'h00;
    rom1[3] = 5'h10;
    rom2[0] = 5'h03;
    rom2[1] = 5'h05;
    rom2[2] = 5'h09;
    rom2[3] = 5'h0C;

    repeat (3) @(negedge clk);
    chk("rst_nv", 32'(nv1), 0);
    chk("rst_mask", 32'(mask1), 0);
    chk("rst_idx", 32'(idx1), 0);
    chk("rst_addr", 32'(addr1), 0);
    chk("rst_play", 32'(play1), 0);
    chk("rst_done", 32'(done1), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    do_beat(0, 0, 4'h0, 0, "idle_beat");
    chk("idle_play", 32'(play1), 0);

    do_start(0, "start");
    do_beat(0, 1, 4'h1, 1, "b0");
    pause = 1'b1;
    do_beat(0, 0, 4'h0, 1, "paused");
    pause = 1'b0;
    do_beat(0, 1, 4'h6, 2, "b1");

    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("run_start_idx", 32'(idx1), 2);
    chk("run_start_play", 32'(play1), 1);

    do_beat(0, 1, 4'h0, 3, "rest");
    do_beat(0, 0, 4'h0, 3, "endmark");
    chk("end_done", 32'(done1), 1);
    chk("end_play", 32'(play1), 0);
    do_beat(0, 0, 4'h0, 3, "done_beat");
    chk("done_hold", 32'(done1), 1);

    do_start(0, "restart");
    do_beat(0, 1, 4'h1, 1, "rb0");

    c0 = nv_cnt;
    @(negedge clk);
    bclk1 = 1'b1;
    repeat (30) @(negedge clk);
    chk("held_high_cnt", 32'(nv_cnt - c0), 1);
    bclk1 = 1'b0;
    repeat (30) @(negedge clk);
    chk("held_low_cnt", 32'(nv_cnt - c0), 1);
    chk("held_idx", 32'(idx1), 2);
    chk("held_mask", 32'(mask1), 4'h6);

    c0 = nv_cnt;
    bclk1 = 1'b1;
    repeat (10) @(negedge clk);
    bclk1 = 1'b0;
    repeat (10) @(negedge clk);
    chk("toggle_cnt", 32'(nv_cnt - c0), 1);
    chk("toggle_idx", 32'(idx1), 3);

    rom1[3] = 5'h08;
    rom1[4] = 5'h02;
    do_beat(0, 1, 4'h8, 4, "b3");
    do_beat(0, 1, 4'h2, 5, "b4");

    do_start(1, "s2");
    do_beat(1, 1, 4'h3, 1, "e0");
    do_beat(1, 1, 4'h5, 2, "e1");
    do_beat(1, 1, 4'h9, 3, "e2");
    do_beat(1, 1, 4'hC, 3, "e3");
    chk("eor_done", 32'(done2), 1);
    do_beat(1, 0, 4'h0, 3, "eor_after");
    chk("eor_mask_held", 32'(mask2), 4'hC);

    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_nv", 32'(nv1), 0);
    chk("mid_rst_mask", 32'(mask1), 0);
    chk("mid_rst_idx", 32'(idx1), 0);
    chk("mid_rst_addr", 32'(addr1), 0);
    chk("mid_rst_play", 32'(play1), 0);
    chk("mid_rst_done2", 32'(done2), 0);
    @(negedge clk);
    rst = 1'b0;
    c0 = nv_cnt;
    repeat (10) @(negedge clk);
    chk("post_rst_cnt", 32'(nv_cnt - c0), 0);
    chk("post_rst_play", 32'(play1), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
